// File: rtl/ir_receiver_sm.sv
// ir_receiver_sm
//   Decodes one car-control IR packet (START, SELECT, CMD_LEN command fields
//   separated by gaps) from a demodulated IR envelope. Mark and space
//   durations are measured in carrier-period ticks and classified against
//   nominal sizes with a +/-TOL window.
// Ports
//   CLK          system clock
//   RESET        synchronous, active-high reset
//   IR_IN        demodulated envelope (1 = carrier present), asynchronous
//   COMMAND      command of the last valid packet, held between packets
//   PACKET_VALID one-cycle strobe: COMMAND updated this cycle
//   PACKET_ERROR one-cycle strobe: packet aborted
//   BUSY         high whenever the decoder is not idle
// Field k of the packet (k = 0 first in time) lands in COMMAND[k].
// Requires CMD_LEN >= 2, CARRIER_DIV >= 2, |ASSERT_SIZE-DEASSERT_SIZE| > 2*TOL.
module ir_receiver_sm #(
  parameter int unsigned CMD_LEN       = 4,
  parameter int unsigned CARRIER_DIV   = 2778,
  parameter int unsigned START_SIZE    = 88,
  parameter int unsigned SELECT_SIZE   = 22,
  parameter int unsigned GAP_SIZE      = 40,
  parameter int unsigned ASSERT_SIZE   = 44,
  parameter int unsigned DEASSERT_SIZE = 22,
  parameter int unsigned TOL           = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               IR_IN,
  output logic [CMD_LEN-1:0] COMMAND,
  output logic               PACKET_VALID,
  output logic               PACKET_ERROR,
  output logic               BUSY
);

  localparam int unsigned PRE_W    = $clog2(CARRIER_DIV);
  localparam int unsigned F_W      = $clog2(CMD_LEN + 2);
  localparam int unsigned LAST_F   = CMD_LEN + 1;
  localparam int unsigned BIT_SIZE = (ASSERT_SIZE > DEASSERT_SIZE) ? ASSERT_SIZE : DEASSERT_SIZE;

  // Lower window edge, clamped at zero.
  function automatic int unsigned lo_of(input int unsigned x);
    return (x > TOL) ? x - TOL : 0;
  endfunction

  localparam logic [CNT_W-1:0] START_LO    = CNT_W'(lo_of(START_SIZE));
  localparam logic [CNT_W-1:0] START_HI    = CNT_W'(START_SIZE + TOL);
  localparam logic [CNT_W-1:0] SELECT_LO   = CNT_W'(lo_of(SELECT_SIZE));
  localparam logic [CNT_W-1:0] SELECT_HI   = CNT_W'(SELECT_SIZE + TOL);
  localparam logic [CNT_W-1:0] ASSERT_LO   = CNT_W'(lo_of(ASSERT_SIZE));
  localparam logic [CNT_W-1:0] ASSERT_HI   = CNT_W'(ASSERT_SIZE + TOL);
  localparam logic [CNT_W-1:0] DEASSERT_LO = CNT_W'(lo_of(DEASSERT_SIZE));
  localparam logic [CNT_W-1:0] DEASSERT_HI = CNT_W'(DEASSERT_SIZE + TOL);
  localparam logic [CNT_W-1:0] BIT_HI      = CNT_W'(BIT_SIZE + TOL);
  localparam logic [CNT_W-1:0] GAP_LO      = CNT_W'(lo_of(GAP_SIZE));
  localparam logic [CNT_W-1:0] GAP_HI      = CNT_W'(GAP_SIZE + TOL);
  localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(CARRIER_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MARK,
    S_SPACE,
    S_TAIL,
    S_RESYNC
  } state_t;

  state_t             state;
  logic               sync1_q;
  logic               sync2_q;
  logic               prev_q;
  logic [PRE_W-1:0]   presc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [F_W-1:0]     field_q;
  logic [CMD_LEN-1:0] shadow_q;

  logic               rise_c;
  logic               fall_c;
  logic               edge_c;
  logic [CNT_W-1:0]   mark_hi_c;
  logic               mark_ok_c;
  logic               mark_bit_c;
  logic               gap_ok_c;
  logic               err_c;

  function automatic logic in_win(input logic [CNT_W-1:0] v,
                                  input logic [CNT_W-1:0] lo,
                                  input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  assign rise_c = sync2_q & ~prev_q;
  assign fall_c = ~sync2_q & prev_q;
  assign edge_c = rise_c | fall_c;

  // Synchronizer, edge history, tick prescaler and saturating duration counter.
  // The edge cycle is prescaler phase 0, so a level held for N*CARRIER_DIV
  // cycles reads exactly N at its terminating edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      presc_q <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= IR_IN;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (edge_c) begin
        presc_q <= PRE_W'(1);
        cnt_q   <= '0;
      end else if (presc_q == PRE_LAST) begin
        presc_q <= '0;
        if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        presc_q <= presc_q + PRE_W'(1);
      end
    end
  end

  // Mark classification for the current field.
  always_comb begin
    mark_hi_c  = BIT_HI;
    mark_ok_c  = 1'b0;
    mark_bit_c = 1'b0;
    if (field_q == '0) begin
      mark_hi_c = START_HI;
      mark_ok_c = in_win(cnt_q, START_LO, START_HI);
    end else if (field_q == F_W'(1)) begin
      mark_hi_c = SELECT_HI;
      mark_ok_c = in_win(cnt_q, SELECT_LO, SELECT_HI);
    end else begin
      mark_bit_c = in_win(cnt_q, ASSERT_LO, ASSERT_HI);
      mark_ok_c  = mark_bit_c | in_win(cnt_q, DEASSERT_LO, DEASSERT_HI);
    end
  end

  assign gap_ok_c = in_win(cnt_q, GAP_LO, GAP_HI);

  // Abort conditions; an edge takes priority over a timeout in the same cycle.
  always_comb begin
    err_c = 1'b0;
    case (state)
      S_MARK:  err_c = fall_c ? ~mark_ok_c : (cnt_q > mark_hi_c);
      S_SPACE: err_c = rise_c ? ~gap_ok_c  : (cnt_q > GAP_HI);
      S_TAIL:  err_c = rise_c;
      default: err_c = 1'b0;
    endcase
  end

  // Packet state machine with registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= S_IDLE;
      field_q      <= '0;
      shadow_q     <= '0;
      COMMAND      <= '0;
      PACKET_VALID <= 1'b0;
      PACKET_ERROR <= 1'b0;
      BUSY         <= 1'b0;
    end else begin
      PACKET_VALID <= 1'b0;
      PACKET_ERROR <= 1'b0;
      if (err_c) begin
        state        <= S_RESYNC;
        shadow_q     <= '0;
        PACKET_ERROR <= 1'b1;
        BUSY         <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (rise_c) begin
              state   <= S_MARK;
              field_q <= '0;
              BUSY    <= 1'b1;
            end
          end
          S_MARK: begin
            if (fall_c) begin
              // Bits shift in from the top so the first field ends in bit 0.
              if (field_q >= F_W'(2)) shadow_q <= {mark_bit_c, shadow_q[CMD_LEN-1:1]};
              state <= (field_q == F_W'(LAST_F)) ? S_TAIL : S_SPACE;
            end
          end
          S_SPACE: begin
            if (rise_c) begin
              state   <= S_MARK;
              field_q <= field_q + F_W'(1);
            end
          end
          S_TAIL: begin
            if (cnt_q >= GAP_LO) begin
              state        <= S_IDLE;
              COMMAND      <= shadow_q;
              PACKET_VALID <= 1'b1;
              BUSY         <= 1'b0;
            end
          end
          S_RESYNC: begin
            // Edges clear the counter, so this needs an unbroken quiet period.
            if (!sync2_q && cnt_q >= GAP_HI) begin
              state <= S_IDLE;
              BUSY  <= 1'b0;
            end
          end
          default: begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
